// File: rtl/fp_stream_minmax.sv
// Streaming IEEE-754 min/max reduction over s_last-delimited packets, one operand per cycle.
// Define FP_MINMAX_ARGIDX_EN to add the m_idx output reporting the winning operand's index.
module fp_stream_minmax #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [EXP_W+FRAC_W:0]   s_data,
    input  logic                    s_last,
    input  logic                    op_min,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [EXP_W+FRAC_W:0]   m_data,
    output logic [CNT_W-1:0]        m_count,
`ifdef FP_MINMAX_ARGIDX_EN
    output logic [CNT_W-1:0]        m_idx,
`endif
    output logic                    m_ovf
);

    localparam int unsigned W = 1 + EXP_W + FRAC_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

    state_e           r_state;
    state_e           w_state_nxt;

    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_ovf;
    logic [W-1:0]     r_m_data;
    logic [CNT_W-1:0] r_m_count;
    logic             r_m_ovf;

    logic             w_accept;
    logic             w_first;
    logic             w_acc_nan;
    logic             w_in_nan;
    logic             w_take;
    logic             w_cnt_sat;
    logic [W-1:0]     w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_mode_nxt;

`ifdef FP_MINMAX_ARGIDX_EN
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_m_idx;
    logic [CNT_W-1:0] w_idx_nxt;
`endif

    function automatic logic is_nan(input logic [W-1:0] v);
        return (&v[W-2:FRAC_W]) && (|v[FRAC_W-1:0]);
    endfunction

    // Strict IEEE ordering on non-NaN bit patterns; bit-equal operands are never greater.
    function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a[W-1] != b[W-1]) begin
            return !a[W-1];
        end else if (!a[W-1]) begin
            return a[W-2:0] > b[W-2:0];
        end else begin
            return a[W-2:0] < b[W-2:0];
        end
    endfunction

    assign w_accept  = s_valid && s_ready;
    assign w_first   = (r_state == StIdle);
    assign w_acc_nan = is_nan(r_acc);
    assign w_in_nan  = is_nan(s_data);
    assign w_cnt_sat = (r_cnt == CntMax);

    always_comb begin
        w_take = 1'b0;
        if (w_acc_nan) begin
            w_take = !w_in_nan;
        end else if (!w_in_nan) begin
            w_take = r_mode ? greater(r_acc, s_data) : greater(s_data, r_acc);
        end
    end

    always_comb begin
        w_acc_nxt  = r_acc;
        w_cnt_nxt  = r_cnt;
        w_ovf_nxt  = r_ovf;
        w_mode_nxt = r_mode;
        if (w_first) begin
            w_acc_nxt  = s_data;
            w_cnt_nxt  = CNT_W'(1);
            w_ovf_nxt  = 1'b0;
            w_mode_nxt = op_min;
        end else begin
            if (w_take) begin
                w_acc_nxt = s_data;
            end
            w_cnt_nxt = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
            w_ovf_nxt = r_ovf | w_cnt_sat;
        end
    end

`ifdef FP_MINMAX_ARGIDX_EN
    // r_cnt equals the current beat's index and already saturates with the count.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_first) begin
            w_idx_nxt = '0;
        end else if (w_take) begin
            w_idx_nxt = r_cnt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StAccum: begin
                if (w_accept) begin
                    w_state_nxt = s_last ? StOut : StAccum;
                end
            end
            StOut: begin
                if (m_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        s_ready = (r_state != StOut);
        m_valid = (r_state == StOut);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_ovf     <= 1'b0;
            r_m_data  <= '0;
            r_m_count <= '0;
            r_m_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_mode <= w_mode_nxt;
            r_ovf  <= w_ovf_nxt;
            if (s_last) begin
                r_m_data  <= w_acc_nxt;
                r_m_count <= w_cnt_nxt;
                r_m_ovf   <= w_ovf_nxt;
            end
        end
    end

`ifdef FP_MINMAX_ARGIDX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_m_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_idx_nxt;
            if (s_last) begin
                r_m_idx <= w_idx_nxt;
            end
        end
    end

    assign m_idx = r_m_idx;
`endif

    assign m_data  = r_m_data;
    assign m_count = r_m_count;
    assign m_ovf   = r_m_ovf;

endmodule

// File: tb/tb_fp_stream_minmax.sv
// Scoreboard bench for fp_stream_minmax: directed FP32 cases plus randomized packets,
// checked against a total-order reference model. A narrow counter exercises saturation.
module tb_fp_stream_minmax;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0]   data;
        logic [CW-1:0] count;
        logic          ovf;
        logic [CW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          op_min = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
    logic [CW-1:0] m_count;
    logic          m_ovf;
`ifdef FP_MINMAX_ARGIDX_EN
    logic [CW-1:0] m_idx;
`endif

    int   n_run  = 0;
    int   n_fail = 0;
    int   bp_mode = 0;   // 0: m_ready high, 1: random, 2: held low
    bit   gaps_en = 1'b0;
    bit   mon_en  = 1'b1;
    exp_t sb[$];

    fp_stream_minmax #(
        .EXP_W (8),
        .FRAC_W(23),
        .CNT_W (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .op_min (op_min),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_count(m_count),
`ifdef FP_MINMAX_ARGIDX_EN
        .m_idx  (m_idx),
`endif
        .m_ovf  (m_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    // Monotone key: unsigned order of keys equals IEEE order, with -0 just below +0.
    function automatic logic [31:0] key(input logic [31:0] v);
        return v[31] ? ~v : (v | 32'h8000_0000);
    endfunction

    function automatic exp_t model(input logic [31:0] ops[$], input logic mn);
        exp_t e;
        int   best = -1;
        int   n = ops.size();
        for (int i = 0; i < n; i++) begin
            if (!is_nan(ops[i])) begin
                if (best < 0) best = i;
                else if (mn ? (key(ops[i]) < key(ops[best])) : (key(ops[i]) > key(ops[best])))
                    best = i;
            end
        end
        if (best < 0) best = 0;
        e.data  = ops[best];
        e.idx   = CW'((best > CMAX) ? CMAX : best);
        e.count = CW'((n > CMAX) ? CMAX : n);
        e.ovf   = (n > CMAX);
        return e;
    endfunction

    function automatic logic [31:0] gen_op(input logic [31:0] prev[$]);
        logic [31:0] v = $urandom;
        case ($urandom_range(0, 9))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = {v[31], 8'hFF, 23'h0};
            3: begin
                v[30:23] = 8'hFF;
                if (v[22:0] == 0) v[0] = 1'b1;
            end
            4: if (prev.size() != 0) v = prev[$urandom_range(0, prev.size() - 1)];
            5: v = {v[31], 8'h7F, 20'h0, v[2:0]};
            default: ;
        endcase
        return v;
    endfunction

    task automatic send_pkt(input logic [31:0] ops[$], input logic mn, input bit flip,
                            input bit push, input bit term, output int first_wait);
        int w;
        bit acc;
        if (push) sb.push_back(model(ops, mn));
        first_wait = 0;
        for (int i = 0; i < ops.size(); i++) begin
            if (gaps_en) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                    s_last  = 1'($urandom_range(0, 1));
                    op_min  = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_data  = ops[i];
            s_last  = term && (i == ops.size() - 1);
            op_min  = (i == 0) ? mn : (flip ? ~mn : mn);
            w = 0;
            do begin
                acc = s_ready;
                @(posedge clk);
                #1;
                w++;
            end while (!acc && w < 100);
            if (!acc) begin
                n_run++;
                n_fail++;
                $display("FAIL accept_timeout: got s_ready=0 for %0d cycles, expected 1", w);
            end
            if (i == 0) first_wait = w;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        check({tag, "_m_data"}, 64'(m_data), 64'(0));
        check({tag, "_m_count"}, 64'(m_count), 64'(0));
        check({tag, "_m_ovf"}, 64'(m_ovf), 64'(0));
        check({tag, "_s_ready"}, 64'(s_ready), 64'(1));
`ifdef FP_MINMAX_ARGIDX_EN
        check({tag, "_m_idx"}, 64'(m_idx), 64'(0));
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en && m_valid) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_result: got m_data %h, expected no result", m_data);
            end else begin
                check("s_ready_low_in_out", 64'(s_ready), 64'(0));
                check("m_data", 64'(m_data), 64'(sb[0].data));
                if (m_ready) begin
                    check("m_count", 64'(m_count), 64'(sb[0].count));
                    check("m_ovf", 64'(m_ovf), 64'(sb[0].ovf));
`ifdef FP_MINMAX_ARGIDX_EN
                    check("m_idx", 64'(m_idx), 64'(sb[0].idx));
`endif
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] ops[$];
        exp_t e;
        int fw;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // Directed FP32 cases
        ops = '{32'h3F80_0000, 32'hC040_0000, 32'h4000_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        send_pkt(ops, 1'b1, 1'b0, 1'b1, 1'b1, fw);
        send_pkt(ops, 1'b1, 1'b1, 1'b1, 1'b1, fw);
        send_pkt(ops, 1'b0, 1'b1, 1'b1, 1'b1, fw);
        ops = '{32'h7FC0_0000, 32'h3F80_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        ops = '{32'h7FC0_0000, 32'h7FC0_0001};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        ops = '{32'h7F80_0000, 32'h7FC0_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        ops = '{32'h8000_0000, 32'h0000_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        send_pkt(ops, 1'b1, 1'b0, 1'b1, 1'b1, fw);
        ops = '{32'h7FC0_0001};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        ops = '{32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);

        // Next first beat lands exactly one cycle after the handshake
        ops = '{32'h3F80_0000, 32'h4040_0000};
        send_pkt(ops, 1'b1, 1'b0, 1'b1, 1'b1, fw);
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        check("b2b_first_accept_edges", 64'(fw), 64'(2));
        drain();

        // Hold off the result for five cycles
        bp_mode = 2;
        @(posedge clk);
        #1;
        ops = '{32'hC120_0000, 32'h4120_0000, 32'hBF80_0000};
        e = model(ops, 1'b1);
        send_pkt(ops, 1'b1, 1'b0, 1'b1, 1'b1, fw);
        repeat (5) begin
            @(negedge clk);
            check("hold_m_valid", 64'(m_valid), 64'(1));
            check("hold_s_ready", 64'(s_ready), 64'(0));
            check("hold_m_data", 64'(m_data), 64'(e.data));
        end
        bp_mode = 0;
        drain();

        // Randomized packets with input gaps and output backpressure
        gaps_en = 1'b1;
        bp_mode = 1;
        for (int p = 0; p < 150; p++) begin
            int n = $urandom_range(1, 20);
            ops = {};
            for (int i = 0; i < n; i++) ops.push_back(gen_op(ops));
            send_pkt(ops, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, fw);
        end
        gaps_en = 1'b0;
        bp_mode = 0;
        drain();

        // Reset mid-accumulation discards the partial packet
        ops = '{32'h4100_0000, 32'h4200_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b0, 1'b0, fw);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("rst_accum");

        // Reset while a result is pending
        mon_en  = 1'b0;
        bp_mode = 2;
        @(posedge clk);
        #1;
        ops = '{32'h4100_0000, 32'h4200_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b0, 1'b1, fw);
        @(negedge clk);
        check("rst_out_pending_valid", 64'(m_valid), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bp_mode = 0;
        @(negedge clk);
        check_zero_outputs("rst_out");
        mon_en = 1'b1;

        ops = '{32'hC040_0000};
        send_pkt(ops, 1'b0, 1'b0, 1'b1, 1'b1, fw);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
